systolic_tile_scheduler: RTL and testbench
==========================================

// Module: systolic_tile_scheduler
// PURPOSE
//   Sequences SystolicArray_Driver over a full M x K x N matrix multiply, C = A * B, in 8x8 tiles.
//   Loop order is i (row tile) outer, j (col tile), k (inner tile) innermost.
//   Per C tile: launch the driver once per k-tile and sum the partial 8x8 results in a local accumulator.
//   When the last k-tile is done, write the C tile to memory.
//   Sits between the top-level command registers and the driver, and owns the memory write port.
// PARAMETERS
//   TILE      8   tile edge; fixed, matches the 8x8 SystolicArray (other values unsupported)
//   WRITE_BW  4   words per write beat; equals `READ_BW
// PORTS
//   clock        in   1                       single clock, all state on posedge
//   reset        in   1                       asynchronous, active-high; forces IDLE
//   start        in   1                       1-cycle command pulse; sampled only in IDLE
//   base_A       in   `ADDR_WIDTH              word address of A[0][0], row-major, dim_K columns
//   base_B       in   `ADDR_WIDTH              word address of B[0][0], row-major, dim_N columns
//   base_C       in   `ADDR_WIDTH              word address of C[0][0], row-major, dim_N columns
//   dim_M        in   `DIM_WIDTH               rows of A/C; multiple of 8 (bits [2:0] ignored)
//   dim_K        in   `DIM_WIDTH               cols of A / rows of B; multiple of 8 (bits [2:0] ignored)
//   dim_N        in   `DIM_WIDTH               cols of B/C; multiple of 8 (bits [2:0] ignored)
//   busy         out  1                       high in every state except IDLE
//   done         out  1                       1-cycle pulse when the whole product is written
//   sa_start     out  1                       1-cycle pulse to the driver's start input
//   sa_base_A    out  `ADDR_WIDTH              driver base_A for the current (i,k) tile
//   sa_base_B    out  `ADDR_WIDTH              driver base_B for the current (k,j) tile
//   sa_dim_col_A out  `DIM_WIDTH               row stride of A; equals dim_K
//   sa_dim_col_B out  `DIM_WIDTH               row stride of B; equals dim_N
//   sa_done      in   1                       driver done pulse
//   sa_Out       in   [7:0][7:0][`DATA_WIDTH-1:0] driver result; valid in the cycle sa_done is high
//   write        out  1                       write request
//   write_addr   out  `ADDR_WIDTH              word address of the first word of the beat
//   write_data   out  [3:0][`DATA_WIDTH-1:0]   4 consecutive C words; word 0 goes to write_addr
//   write_wait   in   1                       memory stall; while high, hold write, addr and data
// BEHAVIOUR
//   - Reset values: busy=0, done=0, sa_start=0, write=0, write_addr=0, write_data=0.
//   - Reset values (cont.): sa_base_*=0, tile counters=0, accumulator=0.
//   - Reset mid-operation aborts at once; the driver is not notified; in-flight writes are dropped.
//   - Command: on start in IDLE, latch all base_* and dim_* values.
//     - Tile counts: TM=dim_M>>3, TK=dim_K>>3, TN=dim_N>>3.
//     - If any count is 0, go to DONE (no sa_start, no writes).
//   - start outside IDLE is ignored. Inputs are not re-sampled mid-command.
//   - sa_base_A = base_A + i*8*dim_K + k*8.
//   - sa_base_B = base_B + k*8*dim_N + j*8.
//   - Address arithmetic is modulo 2^`ADDR_WIDTH and is registered before LAUNCH.
//   - FSM states: IDLE, LAUNCH, WAIT_SA, ACCUM, WRITE, NEXT, DONE.
//     - IDLE:    start -> LAUNCH (or -> DONE for a zero count).
//     - LAUNCH:  sa_start=1 for exactly one cycle -> WAIT_SA.
//     - WAIT_SA: hold until sa_done=1 -> ACCUM. There is no timeout.
//       The sa_Out snapshot is captured in the sa_done cycle.
//     - ACCUM:   one cycle. If k==0, acc <= snapshot; else acc <= acc + snapshot.
//       The add is element-wise, `DATA_WIDTH, wraps (same + as the array).
//       If k<TK-1: k++, -> LAUNCH. Else -> WRITE with beat=0.
//     - WRITE:   16 beats, b=0..15, row r=b>>1, half h=b&1.
//       - write_addr = base_C + (i*8+r)*dim_N + j*8 + h*4.
//       - write_data[w] = acc[r][h*4+w].
//       - A beat completes on any cycle with write=1 && write_wait=0.
//         write stays high back-to-back; beat 15 completing -> NEXT.
//     - NEXT:    k=0. j++; on wrap to 0, i++.
//       If i wraps (all TM*TN tiles written) -> DONE, else -> LAUNCH.
//     - DONE:    done=1 for one cycle, busy=1 -> IDLE.
//   - sa_done outside WAIT_SA is ignored.
//   - write_wait outside WRITE has no effect.
//   - Minimum cycles per C tile = TK*(2 + driver latency + 1) + 16 + 1.
// TESTING
//   1. M=K=N=8, A=I, B[r][c]=r*8+c, bases 0x000/0x100/0x200.
//      -> One sa_start, sa_base_A=0x000, sa_base_B=0x100.
//      -> 16 writes at 0x200,0x204,...,0x23C carrying B's values; one done pulse.
//   2. M=8,K=16,N=8, all ones.
//      -> Two sa_start pulses; second has sa_base_A=0x008, sa_base_B=0x100+64.
//      -> Every written word = 16.
//   3. M=16,K=8,N=16.
//      -> 4 tiles in order (0,0),(0,1),(1,0),(1,1).
//      -> First write_addr of tile (1,1) = base_C + 8*16 + 8.
//   4. write_wait high for 5 cycles during beat 3 -> write, write_addr, write_data stable.
//      Exactly 16 accepted beats; tile total grows by 5 cycles.
//   5. dim_K=0 (or dim_M=4) -> done pulse 2 cycles after start; no sa_start, no write.
//   6. reset asserted in WAIT_SA, and separately in WRITE beat 7.
//      -> All outputs 0 immediately; busy=0.
//      -> A new start runs cleanly; a second start sent mid-run is ignored.

Source files
------------

// File: rtl/systolic_tile_scheduler.sv
// Tiled C = A*B sequencer: walks (i,j,k) 8x8 tiles over the systolic driver,
// accumulates k partials locally and streams each finished C tile out in 4-word beats.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module systolic_tile_scheduler #(
  parameter int TILE     = 8,
  parameter int WRITE_BW = 4
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [`ADDR_WIDTH-1:0]                      base_A,
  input  logic [`ADDR_WIDTH-1:0]                      base_B,
  input  logic [`ADDR_WIDTH-1:0]                      base_C,
  input  logic [`DIM_WIDTH-1:0]                       dim_M,
  input  logic [`DIM_WIDTH-1:0]                       dim_K,
  input  logic [`DIM_WIDTH-1:0]                       dim_N,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        sa_start,
  output logic [`ADDR_WIDTH-1:0]                      sa_base_A,
  output logic [`ADDR_WIDTH-1:0]                      sa_base_B,
  output logic [`DIM_WIDTH-1:0]                       sa_dim_col_A,
  output logic [`DIM_WIDTH-1:0]                       sa_dim_col_B,
  input  logic                                        sa_done,
  input  logic [TILE-1:0][TILE-1:0][`DATA_WIDTH-1:0]  sa_Out,
  output logic                                        write,
  output logic [`ADDR_WIDTH-1:0]                      write_addr,
  output logic [WRITE_BW-1:0][`DATA_WIDTH-1:0]        write_data,
  input  logic                                        write_wait
);

  localparam int CW     = `DIM_WIDTH - 3;
  localparam int NBEATS = TILE * TILE / WRITE_BW;
  localparam int BW     = $clog2(NBEATS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ACCUM  = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [`ADDR_WIDTH-1:0] A_TILE = `ADDR_WIDTH'(TILE);
  localparam logic [`ADDR_WIDTH-1:0] A_BW   = `ADDR_WIDTH'(WRITE_BW);
  localparam logic [BW-1:0]          B_LAST = BW'(NBEATS - 1);

  logic [2:0]                                  r_state;
  logic [`DIM_WIDTH-1:0]                       r_dim_k, r_dim_n;
  logic [CW-1:0]                               r_tm, r_tk, r_tn;
  logic [CW-1:0]                               r_i, r_j, r_k;
  logic [`ADDR_WIDTH-1:0]                      r_base_b;
  logic [`ADDR_WIDTH-1:0]                      r_arow, r_bcol, r_crow, r_cbase;
  logic [`ADDR_WIDTH-1:0]                      r_sa_base_a, r_sa_base_b, r_waddr;
  logic [BW-1:0]                               r_beat;
  logic [TILE-1:0][TILE-1:0][`DATA_WIDTH-1:0]  r_snap, r_acc;

  logic [`ADDR_WIDTH-1:0]                      w_dimn, w_k8, w_n8;
  logic [TILE-1:0][`DATA_WIDTH-1:0]            w_row;
  logic                                        w_zero;
  logic                                        w_unused;

  assign w_dimn = `ADDR_WIDTH'(r_dim_n);
  assign w_k8   = `ADDR_WIDTH'({r_dim_k, 3'b000});
  assign w_n8   = `ADDR_WIDTH'({r_dim_n, 3'b000});
  assign w_zero = (dim_M[`DIM_WIDTH-1:3] == '0) || (dim_K[`DIM_WIDTH-1:3] == '0) ||
                  (dim_N[`DIM_WIDTH-1:3] == '0);
  assign w_unused = ^{dim_M[2:0], dim_K[2:0], dim_N[2:0]};

  // Beat b carries row b>>1, columns (b&1)*WRITE_BW upward.
  assign w_row      = r_acc[r_beat[BW-1:1]];
  assign write_data = r_beat[0] ? w_row[2*WRITE_BW-1:WRITE_BW] : w_row[WRITE_BW-1:0];

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign sa_start     = (r_state == S_LAUNCH);
  assign write        = (r_state == S_WRITE);
  assign write_addr   = r_waddr;
  assign sa_base_A    = r_sa_base_a;
  assign sa_base_B    = r_sa_base_b;
  assign sa_dim_col_A = r_dim_k;
  assign sa_dim_col_B = r_dim_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dim_k     <= '0;
      r_dim_n     <= '0;
      r_tm        <= '0;
      r_tk        <= '0;
      r_tn        <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_base_b    <= '0;
      r_arow      <= '0;
      r_bcol      <= '0;
      r_crow      <= '0;
      r_cbase     <= '0;
      r_sa_base_a <= '0;
      r_sa_base_b <= '0;
      r_waddr     <= '0;
      r_beat      <= '0;
      r_snap      <= '0;
      r_acc       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dim_k     <= {dim_K[`DIM_WIDTH-1:3], 3'b000};
            r_dim_n     <= {dim_N[`DIM_WIDTH-1:3], 3'b000};
            r_tm        <= dim_M[`DIM_WIDTH-1:3];
            r_tk        <= dim_K[`DIM_WIDTH-1:3];
            r_tn        <= dim_N[`DIM_WIDTH-1:3];
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_base_b    <= base_B;
            r_arow      <= base_A;
            r_bcol      <= base_B;
            r_crow      <= base_C;
            r_cbase     <= base_C;
            r_sa_base_a <= base_A;
            r_sa_base_b <= base_B;
            r_state     <= w_zero ? S_DONE : S_LAUNCH;
          end
        end
        S_LAUNCH: r_state <= S_WAIT;
        S_WAIT: begin
          if (sa_done) begin
            r_snap  <= sa_Out;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          for (int unsigned r = 0; r < TILE; r++) begin
            for (int unsigned c = 0; c < TILE; c++) begin
              r_acc[r][c] <= (r_k == '0) ? r_snap[r][c] : r_acc[r][c] + r_snap[r][c];
            end
          end
          if (r_k != r_tk - 1'b1) begin
            r_k         <= r_k + 1'b1;
            r_sa_base_a <= r_sa_base_a + A_TILE;
            r_sa_base_b <= r_sa_base_b + w_n8;
            r_state     <= S_LAUNCH;
          end else begin
            r_beat  <= '0;
            r_waddr <= r_cbase;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!write_wait) begin
            r_beat  <= r_beat + 1'b1;
            // Second half of a row jumps to the start of the next row.
            r_waddr <= r_beat[0] ? r_waddr + w_dimn - A_BW : r_waddr + A_BW;
            if (r_beat == B_LAST) r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          r_k <= '0;
          if (r_j != r_tn - 1'b1) begin
            r_j         <= r_j + 1'b1;
            r_bcol      <= r_bcol + A_TILE;
            r_cbase     <= r_cbase + A_TILE;
            r_sa_base_a <= r_arow;
            r_sa_base_b <= r_bcol + A_TILE;
            r_state     <= S_LAUNCH;
          end else begin
            r_j         <= '0;
            r_bcol      <= r_base_b;
            r_sa_base_b <= r_base_b;
            if (r_i != r_tm - 1'b1) begin
              r_i         <= r_i + 1'b1;
              r_arow      <= r_arow + w_k8;
              r_crow      <= r_crow + w_n8;
              r_cbase     <= r_crow + w_n8;
              r_sa_base_a <= r_arow + w_k8;
              r_state     <= S_LAUNCH;
            end else begin
              r_i         <= '0;
              r_sa_base_a <= r_arow;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Directed bench for systolic_tile_scheduler with a behavioural driver model and
// a word-addressed memory that collects the written C tiles.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_systolic_tile_scheduler;

  localparam int SA_LAT = 3;

  logic                                   clk, rst, start;
  logic [`ADDR_WIDTH-1:0]                 base_A, base_B, base_C;
  logic [`DIM_WIDTH-1:0]                  dim_M, dim_K, dim_N;
  logic                                   busy, done, sa_start, sa_done, write, write_wait;
  logic [`ADDR_WIDTH-1:0]                 sa_base_A, sa_base_B, write_addr;
  logic [`DIM_WIDTH-1:0]                  sa_dim_col_A, sa_dim_col_B;
  logic [7:0][7:0][`DATA_WIDTH-1:0]       sa_Out;
  logic [3:0][`DATA_WIDTH-1:0]            write_data;

  systolic_tile_scheduler #(.TILE(8), .WRITE_BW(4)) dut (
    .clock(clk), .reset(rst), .start(start),
    .base_A(base_A), .base_B(base_B), .base_C(base_C),
    .dim_M(dim_M), .dim_K(dim_K), .dim_N(dim_N),
    .busy(busy), .done(done), .sa_start(sa_start),
    .sa_base_A(sa_base_A), .sa_base_B(sa_base_B),
    .sa_dim_col_A(sa_dim_col_A), .sa_dim_col_B(sa_dim_col_B),
    .sa_done(sa_done), .sa_Out(sa_Out),
    .write(write), .write_addr(write_addr), .write_data(write_data),
    .write_wait(write_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [`DATA_WIDTH-1:0]  mem [0:65535];
  logic [`ADDR_WIDTH-1:0]  la [0:15];
  logic [`ADDR_WIDTH-1:0]  lb [0:15];
  logic [`ADDR_WIDTH-1:0]  waddr_log [0:63];
  int                      n_sa, nbeats, n_done, unstable, stall_cyc;
  bit                      stall_en;
  logic [`ADDR_WIDTH-1:0]  cap_a;
  logic [3:0][`DATA_WIDTH-1:0] cap_d;
  int                      n_checks = 0;
  int                      n_fail = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Behavioural driver: fixed latency, product read from the bench memory.
  initial begin
    logic [7:0][7:0][`DATA_WIDTH-1:0] tmp;
    logic [`DATA_WIDTH-1:0] s;
    bit ab;
    sa_done = 1'b0;
    sa_Out  = '0;
    n_sa    = 0;
    forever begin
      @(negedge clk);
      if (sa_start && !rst) begin
        if (n_sa < 16) begin
          la[n_sa] = sa_base_A;
          lb[n_sa] = sa_base_B;
        end
        n_sa++;
        for (int r = 0; r < 8; r++) begin
          for (int c = 0; c < 8; c++) begin
            s = '0;
            for (int kk = 0; kk < 8; kk++) begin
              s = s + mem[16'(sa_base_A + 16'(r) * 16'(sa_dim_col_A) + 16'(kk))] *
                      mem[16'(sa_base_B + 16'(kk) * 16'(sa_dim_col_B) + 16'(c))];
            end
            tmp[r][c] = s;
          end
        end
        ab = 1'b0;
        for (int c = 0; c < SA_LAT; c++) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
        end
        if (!ab && !rst) begin
          sa_Out  = tmp;
          sa_done = 1'b1;
          @(negedge clk);
          sa_done = 1'b0;
        end
      end
    end
  end

  // Write port: optional 5-cycle stall on beat 3, memory update, done counting.
  initial begin
    write_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_en && write && nbeats == 3 && stall_cyc < 5) begin
        write_wait = 1'b1;
        if (stall_cyc == 0) begin
          cap_a = write_addr;
          cap_d = write_data;
        end else if (write_addr !== cap_a || write_data !== cap_d) begin
          unstable++;
        end
        stall_cyc++;
      end else begin
        write_wait = 1'b0;
      end
      if (done) n_done++;
      if (write && !write_wait) begin
        if (stall_en && nbeats == 3 && (write_addr !== cap_a || write_data !== cap_d)) unstable++;
        if (nbeats < 64) waddr_log[nbeats] = write_addr;
        for (int w = 0; w < 4; w++) mem[16'(write_addr + 16'(w))] = write_data[w];
        nbeats++;
      end
    end
  end

  task automatic clear_all();
    n_sa = 0; nbeats = 0; n_done = 0; unstable = 0; stall_cyc = 0; stall_en = 0;
    for (int a = 0; a < 16'h200; a++) mem[a] = '0;
    for (int a = 16'h200; a < 16'h400; a++) mem[a] = 16'hDEAD;
  endtask

  task automatic load_t1();
    clear_all();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        mem[r*8+c]          = (r == c) ? 16'd1 : 16'd0;
        mem[16'h100+r*8+c]  = 16'(r*8+c);
      end
  endtask

  task automatic set_cmd(input logic [15:0] ba, bb, bc, input logic [11:0] m, k, n);
    base_A = ba; base_B = bb; base_C = bc; dim_M = m; dim_K = k; dim_N = n;
  endtask

  task automatic run_cmd(input string tag, input logic [15:0] ba, bb, bc,
                         input logic [11:0] m, k, n, input int inj_at, output int cyc);
    set_cmd(ba, bb, bc, m, k, n);
    start = 1'b1;
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == inj_at);
      if (cyc == inj_at) set_cmd(16'h0000, 16'h0100, 16'h0300, 12'd16, 12'd8, 12'd16);
      if (done) break;
    end
    check({tag, "_done_seen"}, done, 1);
    repeat (3) @(negedge clk);
  endtask

  function automatic int bad_t1();
    int bad = 0;
    for (int i = 0; i < 64; i++) if (mem[16'h200+i] !== 16'(i)) bad++;
    return bad;
  endfunction

  int cyc1, cyc4, cyc, bad, to;
  logic [15:0] exp_a [0:3];
  logic [15:0] exp_b [0:3];

  initial begin
    rst = 1'b1; start = 1'b0;
    set_cmd('0, '0, '0, '0, '0, '0);
    clear_all();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sa_start", sa_start, 0);
    check("rst_write", write, 0);
    check("rst_waddr", write_addr, 0);
    check("rst_wdata", write_data, 0);
    check("rst_sa_bases", {sa_base_A, sa_base_B}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: identity A, single tile
    load_t1();
    run_cmd("t1", 16'h000, 16'h100, 16'h200, 12'd8, 12'd8, 12'd8, 0, cyc1);
    check("t1_n_sa", n_sa, 1);
    check("t1_baseA", la[0], 16'h000);
    check("t1_baseB", lb[0], 16'h100);
    check("t1_beats", nbeats, 16);
    bad = 0;
    for (int b = 0; b < 16; b++) if (waddr_log[b] !== 16'(16'h200 + 4*b)) bad++;
    check("t1_addr_seq", bad, 0);
    check("t1_cdata", bad_t1(), 0);
    check("t1_n_done", n_done, 1);
    check("t1_strides", {sa_dim_col_A, sa_dim_col_B}, {12'd8, 12'd8});

    // 2: all ones, two k tiles
    clear_all();
    for (int a = 0; a < 128; a++) begin mem[a] = 16'd1; mem[16'h100+a] = 16'd1; end
    run_cmd("t2", 16'h000, 16'h100, 16'h200, 12'd8, 12'd16, 12'd8, 0, cyc);
    check("t2_n_sa", n_sa, 2);
    check("t2_baseA_k1", la[1], 16'h008);
    check("t2_baseB_k1", lb[1], 16'h140);
    check("t2_beats", nbeats, 16);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[16'h200+i] !== 16'd16) bad++;
    check("t2_cdata", bad, 0);

    // 3: 2x2 C tiles, A picks row r%8 of B
    clear_all();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++) mem[r*8+c] = (c == r % 8) ? 16'd1 : 16'd0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) mem[16'h100+r*16+c] = 16'(r*16+c);
    run_cmd("t3", 16'h000, 16'h100, 16'h200, 12'd16, 12'd8, 12'd16, 0, cyc);
    exp_a[0] = 16'h000; exp_a[1] = 16'h000; exp_a[2] = 16'h040; exp_a[3] = 16'h040;
    exp_b[0] = 16'h100; exp_b[1] = 16'h108; exp_b[2] = 16'h100; exp_b[3] = 16'h108;
    check("t3_n_sa", n_sa, 4);
    for (int t = 0; t < 4; t++) begin
      check($sformatf("t3_baseA_%0d", t), la[t], exp_a[t]);
      check($sformatf("t3_baseB_%0d", t), lb[t], exp_b[t]);
    end
    check("t3_beats", nbeats, 64);
    check("t3_tile11_addr", waddr_log[48], 16'h288);
    bad = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) if (mem[16'h200+r*16+c] !== 16'((r%8)*16+c)) bad++;
    check("t3_cdata", bad, 0);

    // 4: write_wait stall on beat 3
    load_t1();
    stall_en = 1'b1;
    run_cmd("t4", 16'h000, 16'h100, 16'h200, 12'd8, 12'd8, 12'd8, 0, cyc4);
    check("t4_stall_cycles", stall_cyc, 5);
    check("t4_unstable", unstable, 0);
    check("t4_beats", nbeats, 16);
    check("t4_extra_cycles", cyc4 - cyc1, 5);
    check("t4_cdata", bad_t1(), 0);

    // 5: zero tile counts
    clear_all();
    run_cmd("t5a", 16'h000, 16'h100, 16'h200, 12'd8, 12'd0, 12'd8, 0, cyc);
    check("t5a_latency_ok", cyc <= 2, 1);
    check("t5a_n_sa", n_sa, 0);
    check("t5a_beats", nbeats, 0);
    check("t5a_n_done", n_done, 1);
    clear_all();
    run_cmd("t5b", 16'h000, 16'h100, 16'h200, 12'd4, 12'd8, 12'd8, 0, cyc);
    check("t5b_latency_ok", cyc <= 2, 1);
    check("t5b_no_activity", n_sa + nbeats, 0);

    // 6a: reset while waiting on the driver
    load_t1();
    set_cmd(16'h000, 16'h100, 16'h200, 12'd8, 12'd8, 12'd8);
    start = 1'b1;
    to = 0;
    while (to < 50) begin @(negedge clk); #1; start = 1'b0; to++; if (n_sa == 1) break; end
    check("t6a_launch_seen", n_sa, 1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("t6a_busy", busy, 0);
    check("t6a_outs", {done, sa_start, write, write_addr, write_data, sa_base_A, sa_base_B}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t6a_quiet", n_done + nbeats, 0);

    // 6b: reset in the middle of beat 7
    load_t1();
    set_cmd(16'h000, 16'h100, 16'h200, 12'd8, 12'd8, 12'd8);
    start = 1'b1;
    to = 0;
    while (to < 100) begin @(negedge clk); #1; start = 1'b0; to++; if (write && nbeats == 7) break; end
    check("t6b_reached_beat7", nbeats, 7);
    rst = 1'b1;
    #1;
    check("t6b_busy", busy, 0);
    check("t6b_outs", {done, sa_start, write, write_addr, write_data, sa_base_A, sa_base_B}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t6b_beats_dropped", nbeats, 7);

    // 6c: clean restart, second start mid-run ignored
    load_t1();
    run_cmd("t6c", 16'h000, 16'h100, 16'h200, 12'd8, 12'd8, 12'd8, 10, cyc);
    check("t6c_n_sa", n_sa, 1);
    check("t6c_beats", nbeats, 16);
    check("t6c_n_done", n_done, 1);
    check("t6c_cdata", bad_t1(), 0);
    check("t6c_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
